// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed memory responder with a ready/data_valid handshake and fixed latency.
// Optional build macro MEM_BURST_EN: reads return an aligned 4-word burst for cache-line fills.
module data_mem_responder #(
  parameter int LATENCY  = 4,
  parameter int MEM_LOG2 = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data_in,
  output logic        o_ready,
  output logic [15:0] o_data_out,
  output logic        o_data_valid
);

  localparam int                CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);

`ifdef MEM_BURST_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;
`endif

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ready;
  logic                 r_data_valid;
  logic [15:0]          r_data_out;
  logic [MEM_LOG2-1:0]  r_idx;
  logic                 r_is_read;
  logic [15:0]          r_mem [2**MEM_LOG2];

  logic                 w_accept;
  logic [MEM_LOG2-1:0]  w_idx;
  logic                 w_unused_bits;

  assign w_accept = i_enable & r_ready;
  assign w_idx    = i_addr[MEM_LOG2:1];

`ifdef MEM_BURST_EN
  logic [1:0]           r_beat;
  logic [1:0]           w_next_beat;
  assign w_next_beat   = r_beat + 2'd1;
  assign w_unused_bits = ^{i_addr[15:MEM_LOG2+1], i_addr[0], r_idx[1:0]};
`else
  assign w_unused_bits = ^{i_addr[15:MEM_LOG2+1], i_addr[0]};
`endif

  // NOTE: the array has no reset branch; contents survive rst and map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_accept && i_wr) begin
      r_mem[w_idx] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_data_valid <= 1'b0;
      r_data_out   <= 16'h0000;
      r_idx        <= '0;
      r_is_read    <= 1'b0;
`ifdef MEM_BURST_EN
      r_beat       <= 2'd0;
`endif
    end else begin
      // NOTE: data_valid defaults low every cycle so each beat is a one-cycle pulse.
      r_data_valid <= 1'b0;
      if (w_accept) begin
        r_state   <= S_WAIT;
        r_cnt     <= '0;
        r_ready   <= 1'b0;
        r_idx     <= w_idx;
        r_is_read <= ~i_wr;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_WAIT: begin
            if (r_cnt == CNT_LAST) begin
`ifdef MEM_BURST_EN
              if (r_is_read) begin
                r_state      <= S_BEAT;
                r_beat       <= 2'd0;
                r_data_valid <= 1'b1;
                r_data_out   <= r_mem[{r_idx[MEM_LOG2-1:2], 2'b00}];
              end else begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
              end
`else
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              if (r_is_read) begin
                r_data_valid <= 1'b1;
                r_data_out   <= r_mem[r_idx];
              end
`endif
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
`ifdef MEM_BURST_EN
          S_BEAT: begin
            if (r_beat == 2'd3) begin
              r_state <= S_IDLE;
            end else begin
              r_beat       <= w_next_beat;
              r_data_valid <= 1'b1;
              r_data_out   <= r_mem[{r_idx[MEM_LOG2-1:2], w_next_beat}];
              // The last beat opens the accept window so a new request overlaps it.
              if (w_next_beat == 2'd3) r_ready <= 1'b1;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ready      = r_ready;
  assign o_data_valid = r_data_valid;
  assign o_data_out   = r_data_out;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic
// checked cycle-by-cycle against an array model and the timing rules of the handshake.
module tb_data_mem_responder;

  localparam int LAT   = 4;
  localparam int ML2   = 10;
  localparam int DEPTH = 1 << ML2;

  logic        clk = 1'b0;
  logic        rst, enable, wr;
  logic [15:0] addr, din;
  logic        ready, dv;
  logic [15:0] dout;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mdl   [DEPTH];
  bit          known [DEPTH];
  logic [15:0] last_out;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(LAT), .MEM_LOG2(ML2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_wr(wr), .i_addr(addr),
    .i_data_in(din), .o_ready(ready), .o_data_out(dout), .o_data_valid(dv)
  );

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  function automatic bit readable(input logic [15:0] a);
`ifdef MEM_BURST_EN
    int b = (widx(a) / 4) * 4;
    return known[b] && known[b+1] && known[b+2] && known[b+3];
`else
    return known[widx(a)];
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request in a cycle where ready is expected high, then follow it cycle by
  // cycle until the responder is ready again. Ends inside that ready cycle.
  task automatic do_request(input bit w, input logic [15:0] a, input logic [15:0] d,
                            input bit hold, input string tag);
    int n;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_at_issue got=%b exp=1", tag, ready);
    end
    enable = 1'b1; wr = w; addr = a; din = d;
    tick;
    if (w) begin
      mdl[widx(a)]   = d;
      known[widx(a)] = 1'b1;
    end
    if (hold) din = 16'h0000;
    else      enable = 1'b0;
    n = LAT;
`ifdef MEM_BURST_EN
    if (!w) n = LAT + 3;
`endif
    for (int j = 0; j <= n; j++) begin
      bit          exp_rdy, exp_dv;
      exp_rdy = (j == n);
      exp_dv  = !w && (j >= LAT);
      if (exp_dv) begin
`ifdef MEM_BURST_EN
        last_out = mdl[(widx(a) / 4) * 4 + (j - LAT)];
`else
        last_out = mdl[widx(a)];
`endif
      end
      checks += 3;
      if (ready !== exp_rdy) begin
        failures++;
        $display("FAIL %s ready cyc=%0d got=%b exp=%b", tag, j, ready, exp_rdy);
      end
      if (dv !== exp_dv) begin
        failures++;
        $display("FAIL %s data_valid cyc=%0d got=%b exp=%b", tag, j, dv, exp_dv);
      end
      if (dout !== last_out) begin
        failures++;
        $display("FAIL %s data_out cyc=%0d got=%h exp=%h", tag, j, dout, last_out);
      end
      if (j < n) tick;
    end
    enable = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    tick;
    checks += 3;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready got=%b exp=1", tag, ready);
    end
    if (dv !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_data_valid got=%b exp=0", tag, dv);
    end
    if (dout !== last_out) begin
      failures++;
      $display("FAIL %s idle_data_out got=%h exp=%h", tag, dout, last_out);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; din = '0;
    tick; tick;
    rst = 1'b0;
    last_out = 16'h0000;
    checks += 3;
    if (ready !== 1'b1)      begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    if (dv !== 1'b0)         begin failures++; $display("FAIL reset_data_valid got=%b exp=0", dv); end
    if (dout !== 16'h0000)   begin failures++; $display("FAIL reset_data_out got=%h exp=0000", dout); end
    idle_cycle("reset_idle");
  endtask

  task automatic test_write_read;
    do_request(1'b1, 16'h0010, 16'h1234, 1'b0, "wr_0010");
    do_request(1'b0, 16'h0010, 16'h0000, 1'b0, "rd_0010");
    checks++;
    if (last_out !== 16'h1234) begin
      failures++;
      $display("FAIL write_read_value got=%h exp=1234", dout);
    end
  endtask

  task automatic test_busy_ignored;
    do_request(1'b1, 16'h0020, 16'hBEEF, 1'b1, "wr_busy_hold");
    do_request(1'b0, 16'h0020, 16'h0000, 1'b0, "rd_0020");
    checks++;
    if (dout !== 16'hBEEF) begin
      failures++;
      $display("FAIL busy_ignored_value got=%h exp=beef", dout);
    end
  endtask

  task automatic test_back_to_back;
    do_request(1'b0, 16'h0010, 16'h0000, 1'b0, "b2b_first");
    do_request(1'b0, 16'h0020, 16'h0000, 1'b0, "b2b_second");
    do_request(1'b1, 16'h0030, 16'h5A5A, 1'b0, "b2b_write");
    do_request(1'b0, 16'h0030, 16'h0000, 1'b0, "b2b_readback");
  endtask

  task automatic test_alias;
    do_request(1'b0, 16'h0011, 16'h0000, 1'b0, "alias_0011");
    do_request(1'b0, 16'h0810, 16'h0000, 1'b0, "alias_0810");
    do_request(1'b0, 16'hF811, 16'h0000, 1'b0, "alias_f811");
  endtask

  task automatic test_reset_mid_read;
    enable = 1'b1; wr = 1'b0; addr = 16'h0010;
    tick;
    enable = 1'b0;
    tick;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", ready); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    last_out = 16'h0000;
    for (int k = 0; k < LAT + 3; k++) begin
      checks += 3;
      if (ready !== 1'b1)    begin failures++; $display("FAIL midrst_ready k=%0d got=%b exp=1", k, ready); end
      if (dv !== 1'b0)       begin failures++; $display("FAIL midrst_data_valid k=%0d got=%b exp=0", k, dv); end
      if (dout !== 16'h0000) begin failures++; $display("FAIL midrst_data_out k=%0d got=%h exp=0000", k, dout); end
      tick;
    end
    do_request(1'b0, 16'h0020, 16'h0000, 1'b0, "midrst_after_rd");
    checks++;
    if (dout !== 16'hBEEF) begin
      failures++;
      $display("FAIL midrst_array_kept got=%h exp=beef", dout);
    end
  endtask

  task automatic test_block_read;
    do_request(1'b1, 16'h0100, 16'h00A0, 1'b0, "blk_pre0");
    do_request(1'b1, 16'h0102, 16'h00A1, 1'b0, "blk_pre1");
    do_request(1'b1, 16'h0104, 16'h00A2, 1'b0, "blk_pre2");
    do_request(1'b1, 16'h0106, 16'h00A3, 1'b0, "blk_pre3");
    do_request(1'b0, 16'h0106, 16'h0000, 1'b0, "blk_read_0106");
    do_request(1'b0, 16'h0102, 16'h0000, 1'b0, "blk_read_0102");
    idle_cycle("blk_idle");
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a, d;
      bit          w, h;
      a = 16'($urandom);
      d = 16'($urandom);
      w = bit'($urandom_range(0, 1));
      if (!w && !readable(a)) w = 1'b1;
      h = w && ($urandom_range(0, 3) == 0);
      do_request(w, a, d, h, w ? "rand_wr" : "rand_rd");
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle("rand_gap");
    end
    // Read back a dense set of previously written words.
    for (int i = 0; i < DEPTH; i += 37) begin
      logic [15:0] a;
      a = 16'(i * 2);
      if (readable(a)) do_request(1'b0, a, 16'h0000, 1'b0, "rand_readback");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset;
    test_write_read;
    test_busy_ignored;
    test_back_to_back;
    test_alias;
    test_reset_mid_read;
    test_block_read;
    test_random;
    idle_cycle("final_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle memory responder for the pipelined CPU's data port. It sits on the far side of the existing memory request interface (enable, wr, addr, data_in) and adds a ready/data_valid handshake, so the core can be exercised against realistic main-memory latency ahead of the cache stage. It holds a word-addressed array, services one request at a time with a fixed, parameterised latency, and optionally returns 4-word aligned bursts for cache-line fills.

## Interface
- LATENCY, 4, cycles from request acceptance to the first read beat or write completion; legal range ≥1
- MEM_LOG2, 10, log2 of the array depth in 16-bit words
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  request strobe; sampled only while ready=1
- wr  in  1  1 = write, 0 = read; qualified by enable
- addr  in  16  byte address; word index = addr[MEM_LOG2:1]; addr[0] and addr[15:MEM_LOG2+1] ignored (aliasing)
- data_in  in  16  write data; qualified by enable & wr
- ready  out  1  responder can accept a request this cycle
- data_out  out  16  read data; meaningful while data_valid=1
- data_valid  out  1  read beat present on data_out

## Operation
- A request is accepted at a rising edge where enable & ready = 1. addr, wr and data_in are captured at that edge.
- Write: the array is updated at the acceptance edge. No data_valid is produced.
- Read: the array is read at the response time, so a write accepted earlier is always visible.
- enable while ready=0 is ignored: no state change and no array write.
- FSM states:
  - IDLE: ready=1.
  - WAIT: counter runs 0 to LATENCY-1; ready=0.
  - BEAT: only built with MEM_BURST_EN.
- FSM transitions:
  - IDLE→WAIT on accept.
  - WAIT→IDLE when the counter reaches LATENCY-1. For a read, data_valid is registered high for the next cycle.
- Because ready is high during the data_valid cycle, a new request can be accepted in that same cycle.
- Counter width is ceil(log2(LATENCY+1)). With LATENCY=1 there is no wait cycle visible: data_valid is high in the cycle after acceptance.
- data_out holds the last returned word between responses.
- Reset values: ready=1, data_valid=0, data_out=16'h0000, FSM=IDLE, counter=0.
- Reset does not clear the array.
- Reset mid-operation aborts the request: no data_valid follows. A write accepted before reset remains in the array.

## Timing
- Accept at edge E0:
  - Single read: data_valid=1 for exactly one cycle, between edges E0+LATENCY and E0+LATENCY+1.
  - Write: ready=0 from E0 to E0+LATENCY; ready=1 again after E0+LATENCY.
- Throughput: one request per LATENCY cycles, since accept and response overlap.
- rst sampled high at edge R: outputs take their reset values after R; ready=1 in the cycle after R.
- Signals are combinational-free from inputs to outputs: ready, data_valid and data_out are all registered.

## Configuration
- MEM_BURST_EN defined:
  - A read returns 4 beats from the aligned block at word indices {addr[MEM_LOG2:3],2'b00} through +3, in ascending order, regardless of addr[2:1].
  - Beats arrive on consecutive cycles. data_valid is high from E0+LATENCY to E0+LATENCY+4.
  - FSM path is WAIT→BEAT; BEAT counts 4 beats.
  - ready=1 only during the last beat, so a new request can be accepted there.
  - Writes are unchanged (single word).
- MEM_BURST_EN undefined: BEAT state and beat counter are not built; reads are single-word as described above.

## Test plan
- Write then read:
  - Write 16'h1234 to 0x0010 (accepted at E0).
  - Read 0x0010 accepted at E4.
  - Expect data_valid only in cycle E8–E9 with data_out=16'h1234.
- Busy request ignored:
  - Write 16'hBEEF to 0x0020 at E0.
  - Hold enable=1, wr=1, data_in=16'h0000 at E1–E3.
  - A subsequent read of 0x0020 returns 16'hBEEF.
- Back-to-back:
  - Read accepted at E0 (data_valid in E4–E5).
  - Second read presented in that same cycle is accepted at E5.
  - Second data_valid appears in E9–E10.
- Reset mid-read:
  - Read accepted at E0; rst=1 at E2.
  - Expect data_valid=0 throughout, data_out=0, and ready=1 after E2.
  - A read issued after reset still returns the pre-reset array contents.
- Aliasing: a read of 0x0011 returns the word written at 0x0010; with MEM_LOG2=10, a read of 0x0810 also returns it.
- Burst (MEM_BURST_EN):
  - Preload 0x0100–0x0106 with 16'hA0, A1, A2, A3.
  - Read 0x0106 accepted at E0.
  - Expect data_out of A0, A1, A2, A3 during E4–E8.
  - Expect ready=1 only during E7–E8.
